// File: rtl/tl_sensor_if.sv
// tl_sensor_if: per-street vehicle queue counters driving Ta/Tb occupancy for the traffic light controller.
// Define TL_DEBOUNCE_EN to insert a DEBOUNCE-sample stability filter after each detector synchronizer.
module tl_sensor_if #(
  parameter int CNT_W         = 4,
  parameter int DEPART_CYCLES = 8,
  parameter int DEBOUNCE      = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             det_a,
  input  logic             det_b,
  input  logic [1:0]       La,
  input  logic [1:0]       Lb,
  output logic             Ta,
  output logic             Tb,
  output logic [CNT_W-1:0] cnt_a,
  output logic [CNT_W-1:0] cnt_b,
  output logic             ovf
);
  localparam int TW = DEPART_CYCLES > 1 ? $clog2(DEPART_CYCLES) : 1;
  localparam logic [CNT_W-1:0] MAX = '1;
  if (DEBOUNCE < 1 || DEPART_CYCLES < 1) begin : g_bad_param
    $error("tl_sensor_if: DEBOUNCE and DEPART_CYCLES must be >= 1");
  end
  logic [1:0] det, s1, s2, filt, filt_d, arr, dep, green, full, occ;
  logic [CNT_W-1:0] cnt [2];
  logic [CNT_W-1:0] cnt_nx [2];
  logic [TW-1:0] tmr [2];
  assign det   = {det_b, det_a};
  assign green = {Lb == 2'b00, La == 2'b00};
  assign arr   = filt & ~filt_d;
  assign full  = {cnt[1] == MAX, cnt[0] == MAX};
`ifdef TL_DEBOUNCE_EN
  localparam int SW = $clog2(DEBOUNCE + 1);
  logic [SW-1:0] stab [2];
  // stab counts consecutive synchronized samples that disagree with the accepted level
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      filt <= '0;
      for (int i = 0; i < 2; i++) stab[i] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (s2[i] == filt[i]) stab[i] <= '0;
        else if (stab[i] == SW'(DEBOUNCE - 1)) begin
          filt[i] <= s2[i];
          stab[i] <= '0;
        end else stab[i] <= stab[i] + 1'b1;
      end
    end
  end
`else
  assign filt = s2;
`endif
  // simultaneous arrival and departure cancel, so a full queue never flags overflow then
  always_comb begin
    dep = '0;
    for (int i = 0; i < 2; i++) begin
      dep[i]    = green[i] && cnt[i] != '0 && tmr[i] == TW'(DEPART_CYCLES - 1);
      cnt_nx[i] = (arr[i] && !dep[i] && cnt[i] != MAX) ? cnt[i] + 1'b1 :
                  (dep[i] && !arr[i]) ? cnt[i] - 1'b1 : cnt[i];
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1     <= '0;
      s2     <= '0;
      filt_d <= '0;
      occ    <= '0;
      ovf    <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        cnt[i] <= '0;
        tmr[i] <= '0;
      end
    end else begin
      s1     <= det;
      s2     <= s1;
      filt_d <= filt;
      ovf    <= ovf | |(arr & ~dep & full);
      for (int i = 0; i < 2; i++) begin
        cnt[i] <= cnt_nx[i];
        occ[i] <= cnt_nx[i] != '0;
        tmr[i] <= (!green[i] || cnt[i] == '0 || dep[i]) ? '0 : tmr[i] + 1'b1;
      end
    end
  end
  assign cnt_a = cnt[0];
  assign cnt_b = cnt[1];
  assign Ta    = occ[0];
  assign Tb    = occ[1];
endmodule

// File: tb/tb_tl_sensor_if.sv
// tb_tl_sensor_if: directed and randomized checks of tl_sensor_if against an event-level queue model.
module tb_tl_sensor_if;
  localparam int CNT_W = 4, DEP = 8, MAXQ = (1 << CNT_W) - 1;
  logic clk = 0, reset_n = 0, det_a = 0, det_b = 0;
  logic [1:0] La = 2'b10, Lb = 2'b10;
  logic Ta, Tb, ovf;
  logic [CNT_W-1:0] cnt_a, cnt_b;
  int pass_cnt = 0, total = 0;
  int mq [2];
  int run [2];
  bit h [2][3];
  bit movf;

  tl_sensor_if #(.CNT_W(CNT_W), .DEPART_CYCLES(DEP), .DEBOUNCE(3)) dut (
    .clk(clk), .reset_n(reset_n), .det_a(det_a), .det_b(det_b), .La(La), .Lb(Lb),
    .Ta(Ta), .Tb(Tb), .cnt_a(cnt_a), .cnt_b(cnt_b), .ovf(ovf));

  always #5 clk = ~clk;

  task automatic model_reset();
    movf = 0;
    for (int i = 0; i < 2; i++) begin
      mq[i] = 0;
      run[i] = 0;
      for (int k = 0; k < 3; k++) h[i][k] = 0;
    end
  endtask

  // Model: an arrival is a 0->1 of the detector as sampled two edges earlier;
  // a departure happens every DEP consecutive edges spent green with a non-empty queue.
  task automatic step();
    for (int i = 0; i < 2; i++) begin
      bit arr, dep, d;
      logic [1:0] l;
      l = i ? Lb : La;
      d = i ? det_b : det_a;
      arr = h[i][1] && !h[i][2];
      dep = 0;
      if (l == 2'b00 && mq[i] > 0) begin
        run[i]++;
        if (run[i] == DEP) begin
          dep = 1;
          run[i] = 0;
        end
      end else run[i] = 0;
      if (arr && !dep) begin
        if (mq[i] == MAXQ) movf = 1;
        else mq[i]++;
      end else if (dep && !arr) mq[i]--;
      h[i][2] = h[i][1];
      h[i][1] = h[i][0];
      h[i][0] = d;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  task automatic pulse(input bit s, input int hi, input int lo);
    if (s) det_b = 1; else det_a = 1;
    steps(hi);
    if (s) det_b = 0; else det_a = 0;
    steps(lo);
  endtask

  task automatic do_reset();
    det_a = 0; det_b = 0; La = 2'b10; Lb = 2'b10;
    reset_n = 0;
    model_reset();
    #3 reset_n = 1;
  endtask

  task automatic test_reset();
    reset_n = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    total++; if (cnt_a !== 0 || cnt_b !== 0) $display("FAIL reset_cnt got %0d/%0d exp 0/0", cnt_a, cnt_b); else pass_cnt++;
    total++; if (Ta !== 0 || Tb !== 0 || ovf !== 0) $display("FAIL reset_flags got Ta=%b Tb=%b ovf=%b exp 0", Ta, Tb, ovf); else pass_cnt++;
    reset_n = 1;
    repeat (5) pulse(0, 4, 4);
    total++; if (cnt_a !== 5 || Ta !== 1) $display("FAIL pre_reset got cnt_a=%0d Ta=%b exp 5/1", cnt_a, Ta); else pass_cnt++;
    #2 reset_n = 0;
    #1;
    total++; if (cnt_a !== 0 || Ta !== 0 || ovf !== 0) $display("FAIL async_reset got cnt_a=%0d Ta=%b ovf=%b exp 0", cnt_a, Ta, ovf); else pass_cnt++;
    model_reset();
    #1 reset_n = 1;
    pulse(0, 4, 4);
    total++; if (cnt_a !== 1 || Ta !== 1) $display("FAIL post_reset got cnt_a=%0d Ta=%b exp 1/1", cnt_a, Ta); else pass_cnt++;
  endtask

  task automatic test_arrival();
    do_reset();
    det_a = 1;
    steps(2);
    total++; if (cnt_a !== 0) $display("FAIL arr_early got %0d exp 0", cnt_a); else pass_cnt++;
    step();
    total++; if (cnt_a !== 1 || Ta !== 1) $display("FAIL arr_latency got cnt_a=%0d Ta=%b exp 1/1", cnt_a, Ta); else pass_cnt++;
    step();
    det_a = 0;
    steps(4);
    pulse(0, 4, 4);
    pulse(0, 4, 4);
    total++; if (cnt_a !== 3 || Ta !== 1) $display("FAIL arr_three got cnt_a=%0d Ta=%b exp 3/1", cnt_a, Ta); else pass_cnt++;
    total++; if (cnt_b !== 0 || Tb !== 0) $display("FAIL arr_indep got cnt_b=%0d Tb=%b exp 0/0", cnt_b, Tb); else pass_cnt++;
    total++; if (cnt_a !== CNT_W'(mq[0])) $display("FAIL arr_model got %0d exp %0d", cnt_a, mq[0]); else pass_cnt++;
  endtask

  task automatic test_drain();
    do_reset();
    pulse(1, 4, 4);
    pulse(1, 4, 4);
    total++; if (cnt_b !== 2) $display("FAIL drain_fill got %0d exp 2", cnt_b); else pass_cnt++;
    Lb = 2'b00;
    steps(7);
    total++; if (cnt_b !== 2) $display("FAIL drain_early got %0d exp 2", cnt_b); else pass_cnt++;
    step();
    total++; if (cnt_b !== 1 || Tb !== 1) $display("FAIL drain_first got cnt_b=%0d Tb=%b exp 1/1", cnt_b, Tb); else pass_cnt++;
    steps(7);
    total++; if (cnt_b !== 1) $display("FAIL drain_mid got %0d exp 1", cnt_b); else pass_cnt++;
    step();
    total++; if (cnt_b !== 0 || Tb !== 0) $display("FAIL drain_empty got cnt_b=%0d Tb=%b exp 0/0", cnt_b, Tb); else pass_cnt++;
    steps(20);
    total++; if (cnt_b !== 0 || cnt_a !== 0) $display("FAIL drain_hold got cnt_b=%0d cnt_a=%0d exp 0/0", cnt_b, cnt_a); else pass_cnt++;
  endtask

  task automatic test_yellow_cut();
    do_reset();
    pulse(0, 4, 4);
    La = 2'b00;
    steps(5);
    La = 2'b01;
    steps(10);
    total++; if (cnt_a !== 1 || Ta !== 1) $display("FAIL yellow_hold got cnt_a=%0d Ta=%b exp 1/1", cnt_a, Ta); else pass_cnt++;
    La = 2'b11;
    steps(12);
    total++; if (cnt_a !== 1) $display("FAIL illegal_hold got %0d exp 1", cnt_a); else pass_cnt++;
    La = 2'b00;
    steps(7);
    total++; if (cnt_a !== 1) $display("FAIL regreen_early got %0d exp 1", cnt_a); else pass_cnt++;
    step();
    total++; if (cnt_a !== 0 || Ta !== 0) $display("FAIL regreen_depart got cnt_a=%0d Ta=%b exp 0/0", cnt_a, Ta); else pass_cnt++;
  endtask

  task automatic test_simultaneous();
    do_reset();
    pulse(0, 4, 4);
    pulse(0, 4, 4);
    La = 2'b00;
    steps(5);
    det_a = 1;
    steps(2);
    total++; if (cnt_a !== 2) $display("FAIL simul_before got %0d exp 2", cnt_a); else pass_cnt++;
    step();
    total++; if (cnt_a !== 2 || ovf !== 0) $display("FAIL simul_cancel got cnt_a=%0d ovf=%b exp 2/0", cnt_a, ovf); else pass_cnt++;
    det_a = 0;
    steps(7);
    total++; if (cnt_a !== 2) $display("FAIL simul_next_early got %0d exp 2", cnt_a); else pass_cnt++;
    step();
    total++; if (cnt_a !== 1) $display("FAIL simul_next got %0d exp 1", cnt_a); else pass_cnt++;
  endtask

  task automatic test_saturation();
    do_reset();
    repeat (15) pulse(0, 2, 2);
    total++; if (cnt_a !== 15 || ovf !== 0) $display("FAIL sat_15 got cnt_a=%0d ovf=%b exp 15/0", cnt_a, ovf); else pass_cnt++;
    pulse(0, 2, 2);
    total++; if (cnt_a !== 15 || ovf !== 1 || Ta !== 1) $display("FAIL sat_16 got cnt_a=%0d ovf=%b Ta=%b exp 15/1/1", cnt_a, ovf, Ta); else pass_cnt++;
    La = 2'b00;
    steps(8);
    total++; if (cnt_a !== 14 || ovf !== 1) $display("FAIL sat_sticky got cnt_a=%0d ovf=%b exp 14/1", cnt_a, ovf); else pass_cnt++;
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 3) == 0) det_a = ~det_a;
      if ($urandom_range(0, 3) == 0) det_b = ~det_b;
      if ($urandom_range(0, 24) == 0) La = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 24) == 0) Lb = 2'($urandom_range(0, 3));
      step();
      total++; if (cnt_a !== CNT_W'(mq[0])) $display("FAIL rand_cnt_a cyc %0d got %0d exp %0d", n, cnt_a, mq[0]); else pass_cnt++;
      total++; if (cnt_b !== CNT_W'(mq[1])) $display("FAIL rand_cnt_b cyc %0d got %0d exp %0d", n, cnt_b, mq[1]); else pass_cnt++;
      total++; if (Ta !== (mq[0] != 0)) $display("FAIL rand_Ta cyc %0d got %b exp %b", n, Ta, mq[0] != 0); else pass_cnt++;
      total++; if (Tb !== (mq[1] != 0)) $display("FAIL rand_Tb cyc %0d got %b exp %b", n, Tb, mq[1] != 0); else pass_cnt++;
      total++; if (ovf !== movf) $display("FAIL rand_ovf cyc %0d got %b exp %b", n, ovf, movf); else pass_cnt++;
    end
  endtask

  task automatic test_debounce();
    do_reset();
    det_a = 1;
    steps(2);
    det_a = 0;
    steps(10);
    total++; if (cnt_a !== 0) $display("FAIL db_glitch got %0d exp 0", cnt_a); else pass_cnt++;
    det_a = 1;
    steps(5);
    total++; if (cnt_a !== 0) $display("FAIL db_early got %0d exp 0", cnt_a); else pass_cnt++;
    step();
    total++; if (cnt_a !== 1 || Ta !== 1) $display("FAIL db_accept got cnt_a=%0d Ta=%b exp 1/1", cnt_a, Ta); else pass_cnt++;
    det_a = 0;
    steps(10);
    total++; if (cnt_a !== 1) $display("FAIL db_single got %0d exp 1", cnt_a); else pass_cnt++;
  endtask

  initial begin
    test_reset();
`ifdef TL_DEBOUNCE_EN
    test_debounce();
`else
    test_arrival();
    test_drain();
    test_yellow_cut();
    test_simultaneous();
    test_saturation();
    test_random();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule

// File: doc/tl_sensor_if.md
Name: tl_sensor_if

Overview:
Vehicle-detection front end for the traffic light controller. It produces the street-occupancy inputs Ta and Tb that the controller's next-state logic consumes. It counts vehicles queued on street A and street B from raw loop-detector pulses, and drains each queue while that street's light is green. Ta/Tb are asserted while the corresponding queue is non-empty.

Parameters:
CNT_W, 4, width of each per-street queue counter; saturates at 2^CNT_W-1
DEPART_CYCLES, 8, clock cycles per vehicle departure while light is green
DEBOUNCE, 3, consecutive stable samples required to accept a detector level (used only with TL_DEBOUNCE_EN)

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
det_a  input  1  raw loop detector, street A; asynchronous; 1 = vehicle over loop
det_b  input  1  raw loop detector, street B; asynchronous
La  input  2  street A light from controller output logic: 00 green, 01 yellow, 10 red, 11 illegal
Lb  input  2  street B light, same encoding
Ta  output  1  street A occupied (cnt_a != 0)
Tb  output  1  street B occupied (cnt_b != 0)
cnt_a  output  CNT_W  street A queue count
cnt_b  output  CNT_W  street B queue count
ovf  output  1  sticky: an arrival was dropped at saturation on either street

Behaviour:
- Reset (reset_n=0, async): cnt_a=cnt_b=0, Ta=Tb=0, ovf=0, synchronizers=0, depart timers=0, filter state=0. Effective on assertion; deassertion is synchronous to clk.
- Input path, per street:
  - 2-FF synchronizer.
  - Filtered level.
  - Arrival = rising edge of the filtered level (one-cycle pulse).
  - Without the optional feature, the filtered level is the synchronizer output.
  - Latency from det_x rise to cnt_x increment: 3 clk cycles without the feature.
- Depart timer, per street:
  - Counts 0..DEPART_CYCLES-1 while the light is green (00) and cnt>0.
  - Departure pulse is generated on terminal count; the timer then wraps to 0.
  - Timer clears to 0 whenever the light is not green or cnt==0.
  - First departure occurs DEPART_CYCLES cycles after green with cnt>0.
- Counter update, per street, each clk:
  - Arrival only: cnt+1. If cnt is already at max, cnt holds and ovf is set.
  - Departure only: cnt-1. A departure never occurs at cnt==0.
  - Arrival and departure in the same cycle: cnt unchanged; no ovf.
- Outputs:
  - Ta/Tb are registered: Ta = (cnt_a != 0) of the current register value, updated the same edge as cnt.
  - No combinational path from any input to any output.
- Illegal light code 11 is treated as red: no departures, and the timer is cleared.
- Yellow is treated as not green: the timer clears, so a vehicle partially timed at the green-to-yellow transition does not depart.
- ovf clears only on reset.
- Streets are fully independent. Both lights green simultaneously is legal here; both queues drain.

Optional Feature:
- Macro: TL_DEBOUNCE_EN
- Defined:
  - Each synchronized detector feeds a stability filter.
  - The filtered level changes only after DEBOUNCE consecutive cycles of the new synchronized value.
  - Glitches shorter than DEBOUNCE cycles are ignored.
  - Arrival latency becomes 2+DEBOUNCE+1 cycles.
- Not defined:
  - The filter is absent; filtered level = synchronizer output.
  - DEBOUNCE is unused.

Test Plan:
- Reset mid-operation: cnt_a=5, Ta=1, assert reset_n=0 asynchronously between edges → cnt_a=0, Ta=0, ovf=0 immediately; counting resumes normally after release.
- Arrival, feature off: La=10, det_a pulses high for 4 cycles, three times → cnt_a=3 and Ta=1 from 3 cycles after the first rise; cnt_b=0, Tb=0.
- Drain: cnt_b=2, Lb switches 10→00 → cnt_b=1 after 8 cycles, cnt_b=0 and Tb=0 after 16 cycles; no further decrement while green.
- Yellow cut: cnt_a=1, La=00 for 5 cycles then 01 → cnt_a stays 1 and Ta stays 1; a later green needs a full 8 cycles to depart.
- Simultaneous events and saturation:
  - Arrival and departure in the same cycle → cnt unchanged.
  - With CNT_W=4, 16 arrivals at red → cnt_a=15 and ovf=1 after the 16th arrival.
- Debounce, TL_DEBOUNCE_EN defined, DEBOUNCE=3: a 2-cycle det_a glitch → no count; a 3-cycle-stable pulse → cnt_a +1 at 6 cycles after rise.
